// File: rtl/cxu_types.sv
// Shared types for the CX write-path invalidation tracker.
// Holds the per-burst tracking record, the invalidation FSM states and line helpers.
package cxu_types;

    localparam int CX_ADDR_W = 32;
    localparam int CX_ID_W   = 13;

    typedef struct packed {
        logic [CX_ADDR_W-1:0] first_line;
        logic [CX_ADDR_W-1:0] last_line;
        logic [CX_ID_W-1:0]   id;
    } inv_track_t;

    typedef enum logic [1:0] {
        INV_IDLE = 2'd0,
        INV_REQ  = 2'd1,
        INV_RESP = 2'd2,
        INV_PASS = 2'd3
    } inv_state_e;

    function automatic logic [CX_ADDR_W-1:0] line_of(input logic [CX_ADDR_W-1:0] addr,
                                                      input int unsigned         line_bytes);
        return addr & ~(CX_ADDR_W'(line_bytes) - 1'b1);
    endfunction

endpackage

// File: rtl/cx_inv_gen_inv_track_fifo.sv
// DEPTH-entry synchronous FIFO of inv_track_t; head is visible combinationally, 1-cycle push->head.
// Push is ignored while full and pop while empty; push and pop together keep the count.
module inv_track_fifo
    import cxu_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       push_vld,
    input  inv_track_t push_dat,
    input  logic       pop_vld,
    output inv_track_t head_dat,
    output logic       full,
    output logic       empty
);
    localparam int PTR_W = $clog2(DEPTH);

    inv_track_t       mem_q [DEPTH];
    inv_track_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_vld & ~empty;
    assign head_dat = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cx_inv_gen.sv
// Holds each AXI write B response until every touched dcache line is invalidated, in AW order.
// B->first inv 1 cycle, 1 cycle per acked line, then B; AW stalls while DEPTH bursts are pending.
module cx_inv_gen
    import cxu_types::*;
#(
    parameter int ADDR_WIDTH = CX_ADDR_W,
    parameter int ID_WIDTH   = CX_ID_W,
    parameter int LINE_BYTES = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic [ID_WIDTH-1:0]   s_awid,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,
    input  logic [ID_WIDTH-1:0]   m_bid,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    output logic [ID_WIDTH-1:0]   s_bid,
    output logic                  inv_valid,
    output logic [ADDR_WIDTH-1:0] inv_addr,
    input  logic                  inv_ack,
    output logic                  o_err
);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(LINE_BYTES);
    localparam logic [ADDR_WIDTH-1:0] TOP_LINE  = ~(LINE_STEP - 1'b1);

    inv_track_t            push_dat;
    inv_track_t            head_dat;
    logic                  fifo_full, fifo_empty;
    logic                  aw_push, fifo_pop;
    logic [11:0]           burst_bytes;
    logic [ADDR_WIDTH:0]   burst_end;
    logic [ADDR_WIDTH-1:0] last_line;

    inv_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic                  err_q, err_d;

    assign m_awvalid = s_awvalid & ~fifo_full;
    assign s_awready = m_awready & ~fifo_full;
    assign aw_push   = s_awvalid & s_awready;
    assign o_err     = err_q;

    // End address carries one extra bit so a burst running past the top of
    // the address space clamps to the last line instead of wrapping to zero.
    always_comb begin
        burst_bytes = (12'(s_awlen) + 12'd1) << s_awsize;
        burst_end   = {1'b0, s_awaddr} + (ADDR_WIDTH+1)'(burst_bytes) - (ADDR_WIDTH+1)'(1);
        last_line   = burst_end[ADDR_WIDTH] ? TOP_LINE
                                            : line_of(burst_end[ADDR_WIDTH-1:0], LINE_BYTES);
        push_dat    = '{first_line: line_of(s_awaddr, LINE_BYTES),
                        last_line:  last_line,
                        id:         s_awid};
    end

    inv_track_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push_vld (aw_push),
        .push_dat (push_dat),
        .pop_vld  (fifo_pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        err_d     = err_q;
        m_bready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = 2'b00;
        s_bid     = '0;
        inv_valid = 1'b0;
        inv_addr  = '0;
        fifo_pop  = 1'b0;
        case (state_q)
            INV_IDLE: begin
                if (m_bvalid) begin
                    if (!fifo_empty) begin
                        bresp_d = m_bresp;
                        bid_d   = m_bid;
                        cur_d   = head_dat.first_line;
                        if (m_bid != head_dat.id) begin
                            err_d = 1'b1;
                        end
                        state_d = INV_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = INV_PASS;
                    end
                end
            end
            INV_REQ: begin
                inv_valid = 1'b1;
                inv_addr  = cur_q;
                if (inv_ack) begin
                    if (cur_q == head_dat.last_line) begin
                        state_d = INV_RESP;
                    end else begin
                        cur_d = cur_q + LINE_STEP;
                    end
                end
            end
            INV_RESP: begin
                s_bvalid = 1'b1;
                s_bresp  = bresp_q;
                s_bid    = bid_q;
                // Memory has held its B since IDLE; release it together with the master's accept.
                if (s_bready) begin
                    m_bready = 1'b1;
                    fifo_pop = 1'b1;
                    state_d  = INV_IDLE;
                end
            end
            INV_PASS: begin
                s_bvalid = m_bvalid;
                s_bresp  = m_bresp;
                s_bid    = m_bid;
                m_bready = s_bready;
                if (m_bvalid && s_bready) begin
                    state_d = INV_IDLE;
                end
            end
            default: state_d = INV_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= INV_IDLE;
            cur_q   <= '0;
            bresp_q <= '0;
            bid_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            bresp_q <= bresp_d;
            bid_q   <= bid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cx_inv_gen.sv
// Directed bench for cx_inv_gen with a transaction-level model checked every cycle.
// Literal expectations at the end of each scenario pin the model itself.
module tb_cx_inv_gen;
    localparam int AW    = 32;
    localparam int IW    = 13;
    localparam int LB    = 32;
    localparam int DEPTH = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          s_awvalid, s_awready, m_awvalid, m_awready;
    logic [AW-1:0] s_awaddr;
    logic [7:0]    s_awlen;
    logic [2:0]    s_awsize;
    logic [IW-1:0] s_awid;
    logic          m_bvalid, m_bready, s_bvalid, s_bready;
    logic [1:0]    m_bresp, s_bresp;
    logic [IW-1:0] m_bid, s_bid;
    logic          inv_valid, inv_ack, o_err;
    logic [AW-1:0] inv_addr;

    always #5 i_clk = ~i_clk;

    cx_inv_gen #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .LINE_BYTES(LB), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awid(s_awid),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
        .inv_valid(inv_valid), .inv_addr(inv_addr), .inv_ack(inv_ack), .o_err(o_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for handshake (cycle %0d)", name, cyc);
    endtask

    // ---------------- transaction model ----------------
    typedef struct {
        logic [31:0] addr;
        int          len;
        int          size;
        logic [12:0] id;
    } burst_t;

    burst_t            pend[$];
    longint unsigned   exp_inv[$];
    logic [31:0]       inv_log[$];
    bit                busy, pass_mode, exp_err;
    logic [1:0]        exp_resp;
    logic [12:0]       exp_bid;
    logic [1:0]        last_bresp;
    logic [12:0]       last_bid;
    int                pop_cyc, aw_acc_cyc;
    bit                prev_hold;
    logic [31:0]       prev_addr;
    longint unsigned   m_first, m_end, m_last;

    always @(negedge i_clk) begin
        if (i_rst) begin
            check("rst_inv_valid", inv_valid, 0);
            check("rst_s_bvalid", s_bvalid, 0);
            check("rst_m_bready", m_bready, 0);
            check("rst_o_err", o_err, 0);
            pend.delete();
            exp_inv.delete();
            busy = 0; pass_mode = 0; exp_err = 0; prev_hold = 0;
        end else begin
            check("o_err", o_err, exp_err);
            check("m_awvalid", m_awvalid, s_awvalid && pend.size() < DEPTH);
            check("s_awready", s_awready, m_awready && pend.size() < DEPTH);
            if (prev_hold && inv_valid) check("inv_addr_stable", inv_addr, prev_addr);
            if (inv_valid && inv_ack) inv_log.push_back(inv_addr);
            if (s_bvalid && s_bready) begin
                last_bresp = s_bresp; last_bid = s_bid; pop_cyc = cyc;
            end
            if (s_awvalid && s_awready) aw_acc_cyc = cyc;

            if (!busy) begin
                check("idle_inv_valid", inv_valid, 0);
                check("idle_s_bvalid", s_bvalid, 0);
                check("idle_m_bready", m_bready, 0);
                if (m_bvalid) begin
                    busy = 1;
                    if (pend.size() > 0) begin
                        pass_mode = 0;
                        exp_resp  = m_bresp;
                        exp_bid   = m_bid;
                        if (m_bid != pend[0].id) exp_err = 1;
                        m_first = pend[0].addr - (pend[0].addr % LB);
                        m_end   = longint'(pend[0].addr)
                                + (longint'(pend[0].len) + 1) * (longint'(1) << pend[0].size) - 1;
                        if (m_end >= 64'h1_0000_0000) m_last = 64'h1_0000_0000 - LB;
                        else                           m_last = m_end - (m_end % LB);
                        for (longint unsigned x = m_first; x <= m_last; x += LB) exp_inv.push_back(x);
                    end else begin
                        pass_mode = 1;
                        exp_err   = 1;
                    end
                end
            end else if (pass_mode) begin
                check("pass_s_bvalid", s_bvalid, m_bvalid);
                check("pass_s_bresp", s_bresp, m_bresp);
                check("pass_s_bid", s_bid, m_bid);
                check("pass_m_bready", m_bready, s_bready);
                check("pass_inv_valid", inv_valid, 0);
                if (m_bvalid && s_bready) busy = 0;
            end else if (exp_inv.size() > 0) begin
                check("inv_valid", inv_valid, 1);
                check("inv_addr", inv_addr, exp_inv[0]);
                check("inv_s_bvalid", s_bvalid, 0);
                check("inv_m_bready", m_bready, 0);
                if (inv_ack) void'(exp_inv.pop_front());
            end else begin
                check("resp_s_bvalid", s_bvalid, 1);
                check("resp_inv_valid", inv_valid, 0);
                check("resp_s_bresp", s_bresp, exp_resp);
                check("resp_s_bid", s_bid, exp_bid);
                check("resp_m_bready", m_bready, s_bready);
                if (s_bready) begin
                    busy = 0;
                    void'(pend.pop_front());
                end
            end

            if (s_awvalid && s_awready)
                pend.push_back('{s_awaddr, int'(s_awlen), int'(s_awsize), s_awid});
            prev_hold = inv_valid && !inv_ack;
            prev_addr = inv_addr;
        end
    end

    // ---------------- invalidation acknowledger ----------------
    int ack_delay = 0;
    int ack_cnt   = 0;
    always @(posedge i_clk) begin
        #1;
        if (inv_valid) begin
            if (ack_cnt >= ack_delay) begin
                inv_ack = 1'b1;
                ack_cnt = 0;
            end else begin
                inv_ack = 1'b0;
                ack_cnt++;
            end
        end else begin
            inv_ack = 1'b0;
            ack_cnt = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [12:0] id);
        bit done = 0;
        s_awvalid = 1; s_awaddr = a; s_awlen = l; s_awsize = s; s_awid = id;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge i_clk);
            if (s_awready) done = 1;
        end
        if (!done) timeout("aw_handshake");
        tick();
        s_awvalid = 0;
    endtask

    task automatic do_b(input logic [1:0] resp, input logic [12:0] id);
        bit done = 0;
        m_bvalid = 1; m_bresp = resp; m_bid = id;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge i_clk);
            if (m_bready) done = 1;
        end
        if (!done) timeout("b_handshake");
        tick();
        m_bvalid = 0;
    endtask

    task automatic do_reset();
        i_rst = 1; s_awvalid = 0; m_bvalid = 0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        i_rst = 1; s_awvalid = 0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awid = '0;
        m_awready = 1; m_bvalid = 0; m_bresp = '0; m_bid = '0; s_bready = 1; inv_ack = 0;
        do_reset();
        @(negedge i_clk);
        check("reset_s_awready", s_awready, 1);
        check("reset_o_err", o_err, 0);
        tick();

        // Single line burst.
        inv_log.delete();
        do_aw(32'h1000, 8'd3, 3'd3, 13'h011);
        do_b(2'd1, 13'h011);
        tick();
        check("t1_inv_count", inv_log.size(), 1);
        check("t1_inv0", inv_log[0], 32'h1000);
        check("t1_bresp", last_bresp, 2'd1);
        check("t1_bid", last_bid, 13'h011);

        // Line-crossing burst with slow acks.
        ack_delay = 3;
        inv_log.delete();
        do_aw(32'h101C, 8'd1, 3'd3, 13'h022);
        do_b(2'd0, 13'h022);
        tick();
        ack_delay = 0;
        check("t2_inv_count", inv_log.size(), 2);
        check("t2_inv0", inv_log[0], 32'h1000);
        check("t2_inv1", inv_log[1], 32'h1020);
        check("t2_bid", last_bid, 13'h022);

        // Burst running past the top of the address space.
        inv_log.delete();
        do_aw(32'hFFFF_FFF0, 8'd3, 3'd3, 13'h007);
        do_b(2'd0, 13'h007);
        tick();
        check("wrap_inv_count", inv_log.size(), 1);
        check("wrap_inv0", inv_log[0], 32'hFFFF_FFE0);

        // Fill all tracking slots, then a fifth AW must wait for one pop.
        for (int i = 0; i < 4; i++) do_aw(32'h4000 + 32'(i) * 32'h40, 8'd0, 3'd3, 13'(i + 1));
        s_awvalid = 1; s_awaddr = 32'h5000; s_awlen = 0; s_awsize = 3; s_awid = 13'h005;
        @(negedge i_clk);
        check("full_s_awready", s_awready, 0);
        check("full_m_awvalid", m_awvalid, 0);
        tick();
        fork
            do_b(2'd0, 13'h001);
            begin
                done = 0;
                for (int n = 0; n < 200 && !done; n++) begin
                    @(negedge i_clk);
                    if (s_awready) done = 1;
                end
                if (!done) timeout("aw5_handshake");
                tick();
                s_awvalid = 0;
            end
        join
        check("aw5_after_pop", aw_acc_cyc - pop_cyc, 1);
        for (int i = 2; i <= 5; i++) do_b(2'd0, 13'(i));
        tick();
        check("drain_o_err", o_err, 0);

        // Mismatched response ID.
        inv_log.delete();
        do_aw(32'h6000, 8'd0, 3'd3, 13'h00A);
        do_b(2'd3, 13'h00B);
        tick();
        check("t4_o_err", o_err, 1);
        check("t4_inv0", inv_log[0], 32'h6000);
        check("t4_bresp", last_bresp, 2'd3);
        check("t4_bid", last_bid, 13'h00B);
        tick();
        check("t4_o_err_sticky", o_err, 1);

        // B with nothing tracked passes straight through.
        do_reset();
        @(negedge i_clk);
        check("t5_err_cleared", o_err, 0);
        tick();
        do_b(2'd2, 13'h033);
        tick();
        check("t5_o_err", o_err, 1);
        check("t5_bresp", last_bresp, 2'd2);
        check("t5_bid", last_bid, 13'h033);

        // Asynchronous reset while invalidating.
        do_reset();
        ack_delay = 20;
        do_aw(32'h2000, 8'd7, 3'd3, 13'h044);
        m_bvalid = 1; m_bresp = 0; m_bid = 13'h044;
        tick();
        tick();
        @(negedge i_clk);
        check("t6_inv_before_rst", inv_valid, 1);
        @(posedge i_clk);
        #3;
        i_rst = 1;
        #1;
        check("t6_inv_drop", inv_valid, 0);
        check("t6_bvalid_drop", s_bvalid, 0);
        m_bvalid = 0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 0;
        ack_delay = 0;
        @(negedge i_clk);
        check("t6_awready", s_awready, 1);
        tick();
        inv_log.delete();
        do_aw(32'h3000, 8'd0, 3'd3, 13'h055);
        do_b(2'd0, 13'h055);
        tick();
        check("t6_inv_count", inv_log.size(), 1);
        check("t6_inv0", inv_log[0], 32'h3000);
        check("t6_o_err", o_err, 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
